// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte/grant widths,
// FSM state encoding and the cyclic index helper.
package uart_pkg;

    localparam int BYTE_W  = 8;
    localparam int GRANT_W = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_WAIT_BUSY = 3'd2;
    localparam state_t ST_WAIT_STOP = 3'd3;
    localparam state_t ST_DONE      = 3'd4;
    localparam state_t ST_GAP       = 3'd5;

    // Next requester index after idx, wrapping n-1 back to 0.
    function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx,
                                                    input int n);
        int v;
        v = int'(idx) + 1;
        if (v >= n) v = 0;
        return GRANT_W'(v);
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: first requester with req set,
// scanning ptr, ptr+1, ... modulo N_REQ.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic [GRANT_W-1:0] grant_o,
    output logic               valid_o
);

    logic [N_REQ-1:0]   rot;
    logic [GRANT_W-1:0] off;
    logic [GRANT_W:0]   sum;

    always_comb begin
        // Rotate so that bit 0 of rot is the requester at the pointer.
        rot = N_REQ'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = GRANT_W'(k);
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (GRANT_W + 1)'(N_REQ)) sum = sum - (GRANT_W + 1)'(N_REQ);
        grant_o = sum[GRANT_W-1:0];
        valid_o = |req_i;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART byte transmitter among N_REQ requesters: round-robin grant,
// start pulse, hold byte for the frame, ack on end-of-frame, timeout abort.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GAP_CYC = 0,
    parameter int TIMEOUT = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [BYTE_W*N_REQ-1:0] dat_in,
    output logic [N_REQ-1:0]        ack,
    output logic                    tx_st,
    output logic [BYTE_W-1:0]       tx_dat,
    input  logic                    tx_busy,
    input  logic                    tx_ce_stop,
    output logic [GRANT_W-1:0]      grant_id,
    output logic                    busy,
    output logic                    err_to,
    output logic [2:0]              state_dbg
);

    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    state_t             state_q, state_d;
    logic [GRANT_W-1:0] ptr_q, ptr_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [BYTE_W-1:0]  dat_q, dat_d;
    logic [31:0]        to_cnt_q, to_cnt_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;

    logic [GRANT_W-1:0] pick_grant;
    logic               pick_valid;
    logic               in_wait;
    logic               timeout_hit;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    assign in_wait     = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_STOP);
    assign timeout_hit = in_wait && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        dat_d     = dat_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    dat_d   = BYTE_W'(dat_in >> {pick_grant, 3'b000});
                    state_d = ST_START;
                end
            end
            ST_START: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (timeout_hit) begin
                    ptr_d   = wrap_inc(grant_q, N_REQ);
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                    if (tx_busy) state_d = ST_WAIT_STOP;
                end
            end
            ST_WAIT_STOP: begin
                // End-of-frame beats a coincident timeout.
                if (tx_ce_stop) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    ptr_d   = wrap_inc(grant_q, N_REQ);
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                ptr_d     = wrap_inc(grant_q, N_REQ);
                gap_cnt_d = '0;
                state_d   = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
                else gap_cnt_d = gap_cnt_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            dat_q     <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            dat_q     <= dat_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign tx_st     = (state_q == ST_START);
    assign ack       = (state_q == ST_DONE) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign err_to    = timeout_hit && !((state_q == ST_WAIT_STOP) && tx_ce_stop);
    assign busy      = (state_q != ST_IDLE);
    assign tx_dat    = dat_q;
    assign grant_id  = grant_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb: TX core stub, request drivers and a
// scoreboard fed by a cyclic-scan reference model.
module tb_uart_tx_arb;
    import uart_pkg::*;

    localparam int N   = 4;
    localparam int GAP = 10;
    localparam int TO  = 50;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] dat_in = '0;
    logic [N-1:0]   ack;
    logic           tx_st;
    logic [7:0]     tx_dat;
    logic           tx_busy = 1'b0;
    logic           tx_ce_stop = 1'b0;
    logic [2:0]     grant_id;
    logic           busy;
    logic           err_to;
    logic [2:0]     state_dbg;

    always #5 clk = ~clk;

    uart_tx_arb #(.N_REQ(N), .GAP_CYC(GAP), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .dat_in     (dat_in),
        .ack        (ack),
        .tx_st      (tx_st),
        .tx_dat     (tx_dat),
        .tx_busy    (tx_busy),
        .tx_ce_stop (tx_ce_stop),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_to     (err_to),
        .state_dbg  (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // Entry: {timeout_expected, requester id, byte}
    logic [11:0] exp_q[$];
    logic [7:0]  bytes_m[N];
    int          ptr_m = 0;
    bit          mute = 1'b0;
    bit          auto_drop = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int first_from(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // All bits of mask raised together and each held until served.
    task automatic model_batch(input logic [N-1:0] mask, input bit to_first);
        logic [N-1:0] m;
        int           g;
        bit           tflag;
        m = mask;
        tflag = to_first;
        while (m != '0) begin
            g = first_from(m, ptr_m);
            exp_q.push_back({tflag, 3'(g), bytes_m[g]});
            m[g]  = 1'b0;
            ptr_m = (g + 1) % N;
            tflag = 1'b0;
        end
    endtask

    // ---------------- TX core stub ----------------
    int         ph = 0;
    int         dly = 0;
    int         len = 0;
    logic [7:0] cap = '0;

    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            ph = 0;
            tx_busy = 1'b0;
            tx_ce_stop = 1'b0;
        end else begin
            case (ph)
                0: begin
                    tx_ce_stop = 1'b0;
                    tx_busy = 1'b0;
                    if (tx_st && !mute) begin
                        ph  = 1;
                        dly = $urandom_range(0, 2);
                        cap = tx_dat;
                    end
                end
                1: begin
                    if (dly == 0) begin
                        tx_busy = 1'b1;
                        len = $urandom_range(2, 12);
                        ph  = 2;
                    end else begin
                        dly--;
                    end
                end
                2: begin
                    chk("dat_stable", tx_dat, cap);
                    if (len == 0) begin
                        tx_busy = 1'b0;
                        tx_ce_stop = 1'b1;
                        ph = 0;
                    end else begin
                        len--;
                    end
                end
                default: ph = 0;
            endcase
        end
    end

    // Requesters withdraw once acknowledged.
    initial forever begin
        @(negedge clk);
        if (auto_drop && rst_n) req = req & ~ack;
    end

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0;
    int          st_cyc = 0;
    bit          gap_on = 1'b0;
    int          gap_n = 0;
    bit          to_idle = 1'b0;
    logic [11:0] e;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            gap_on = 1'b0;
            to_idle = 1'b0;
            continue;
        end
        if (gap_on) begin
            if (busy) gap_n++;
            else begin
                chk("gap_len", gap_n, GAP);
                gap_on = 1'b0;
            end
        end
        if (tx_st) begin
            chk("st_not_busy", tx_busy, 0);
            st_cyc = cyc;
        end
        if (to_idle) begin
            chk("to_state_idle", state_dbg, ST_IDLE);
            chk("to_busy_low", busy, 0);
            to_idle = 1'b0;
        end
        if (ack != '0 || err_to) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: ack=%0h err_to=%0b expected none", ack, err_to);
            end else begin
                e = exp_q.pop_front();
                chk("grant_id", grant_id, e[10:8]);
                chk("tx_dat", tx_dat, e[7:0]);
                if (e[11]) begin
                    chk("to_err", err_to, 1);
                    chk("to_no_ack", ack, 0);
                    chk("to_latency", cyc - st_cyc, TO);
                    to_idle = 1'b1;
                end else begin
                    chk("ack_onehot", ack, 1 << e[10:8]);
                    chk("ack_no_err", err_to, 0);
                    gap_on = 1'b1;
                    gap_n = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_dat(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                bytes_m[i] = 8'($urandom_range(0, 255));
                dat_in[8*i +: 8] = bytes_m[i];
            end
        end
    endtask

    task automatic start_batch(input logic [N-1:0] mask, input bit lat);
        @(posedge clk);
        #2;
        req = req | mask;
        if (lat) begin
            @(negedge clk);
            chk("lat_idle_no_st", tx_st, 0);
            @(negedge clk);
            chk("lat_st", tx_st, 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || req != '0 || exp_q.size() != 0) && n < 3000);
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%0b req=%0h pending=%0d after %0d cycles",
                     busy, req, exp_q.size(), n);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n_ack;
        int          n;
        int          first;
        logic [N-1:0] mask;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_st", tx_st, 0);
        chk("rst_ack", ack, 0);
        chk("rst_tx_dat", tx_dat, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err_to", err_to, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // All four held: 0,1,2,3,0
        auto_drop = 1'b0;
        bytes_m[0] = 8'h11; bytes_m[1] = 8'h22; bytes_m[2] = 8'h33; bytes_m[3] = 8'h44;
        dat_in = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 5; k++) begin
            first = first_from(4'hF, ptr_m);
            exp_q.push_back({1'b0, 3'(first), bytes_m[first]});
            ptr_m = (first + 1) % N;
        end
        start_batch(4'hF, 1'b1);
        n_ack = 0;
        n = 0;
        while (n_ack < 5 && n < 2000) begin
            @(negedge clk);
            n++;
            if (ack != '0) n_ack++;
        end
        req = '0;
        if (n_ack < 5) begin
            checks++;
            errors++;
            $display("FAIL held_acks: got %0d acks expected 5", n_ack);
        end
        auto_drop = 1'b1;
        wait_idle();

        // Pointer fairness
        set_dat(4'b0100);
        model_batch(4'b0100, 1'b0);
        start_batch(4'b0100, 1'b1);
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            set_dat(4'b0101);
            model_batch(4'b0101, 1'b0);
            start_batch(4'b0101, 1'b1);
            wait_idle();
        end

        // Random batches
        for (int k = 0; k < 16; k++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            set_dat(mask);
            model_batch(mask, 1'b0);
            start_batch(mask, 1'b1);
            wait_idle();
        end

        // Timeout: TX never goes busy for the first frame
        mute = 1'b1;
        mask = 4'b0011;
        set_dat(mask);
        first = first_from(mask, ptr_m);
        model_batch(mask, 1'b1);
        start_batch(mask, 1'b1);
        n = 0;
        while (!err_to && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!err_to) begin
            checks++;
            errors++;
            $display("FAIL to_wait: err_to never seen, expected after %0d cycles", TO);
        end
        req[first] = 1'b0;
        mute = 1'b0;
        wait_idle();

        // Async reset in WAIT_STOP, then re-grant from pointer 0
        set_dat(4'b1000);
        model_batch(4'b1000, 1'b0);
        start_batch(4'b1000, 1'b1);
        n = 0;
        while (state_dbg != ST_WAIT_STOP && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait_stop", state_dbg, ST_WAIT_STOP);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_st", tx_st, 0);
        chk("arst_ack", ack, 0);
        chk("arst_tx_dat", tx_dat, 0);
        chk("arst_grant_id", grant_id, 0);
        chk("arst_err_to", err_to, 0);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        ptr_m = 0;
        set_dat(4'b0010);
        req[1] = 1'b1;
        model_batch(4'b1010, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_idle();

        // End-of-frame strobe while idle is ignored
        @(posedge clk);
        #3;
        tx_ce_stop = 1'b1;
        tx_busy = 1'b1;
        @(posedge clk);
        #3;
        tx_ce_stop = 1'b0;
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ce_busy", busy, 0);
        chk("idle_ce_state", state_dbg, ST_IDLE);
        mask = N'($urandom_range(1, (1 << N) - 1));
        set_dat(mask);
        model_batch(mask, 1'b0);
        start_batch(mask, 1'b1);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
